// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = host link / memory side.
interface imem_loader_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   modport master (
      input  in_data, in_valid,
      output in_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory as LE words.
// Optional trailer XOR check enabled by defining CHECKSUM_EN.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   imem_loader_if.master bus,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] word_cnt
);

   typedef enum logic [2:0] {
      IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR
`ifdef CHECKSUM_EN
      , CSUM
`endif
   } state_t;

`ifdef CHECKSUM_EN
   localparam state_t FIN = CSUM;
`else
   localparam state_t FIN = DONE;
`endif

   localparam logic [16:0] MAXW = 17'(MAX_WORDS);

   state_t      state, nstate;
   logic [15:0] n;
   logic [1:0]  bidx;
   logic [31:0] wdata, waddr;
   logic        rdy, wen, bsy, dn, er;
   logic        take, last, can_start;
   logic [15:0] n_full;
`ifdef CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign take      = bus.in_valid && rdy;
   assign n_full    = {bus.in_data, n[7:0]};
   assign last      = (word_cnt + 16'd1) == n;
   assign can_start = start &&
                      (state == IDLE || state == DONE || state == ERR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      rdy    = 1'b0;
      wen    = 1'b0;
      bsy    = 1'b0;
      dn     = 1'b0;
      er     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) nstate = HDR0;
         end
         HDR0: begin
            rdy = 1'b1;
            bsy = 1'b1;
            if (take) nstate = HDR1;
         end
         HDR1: begin
            rdy = 1'b1;
            bsy = 1'b1;
            if (take) begin
               if (n_full == 16'd0)             nstate = FIN;
               else if ({1'b0, n_full} > MAXW)  nstate = ERR;
               else                             nstate = DATA;
            end
         end
         DATA: begin
            rdy = 1'b1;
            bsy = 1'b1;
            if (take && bidx == 2'd3) nstate = WRITE;
         end
         WRITE: begin
            wen    = 1'b1;
            bsy    = 1'b1;
            nstate = last ? FIN : DATA;
         end
         DONE: begin
            dn = 1'b1;
            if (start) nstate = HDR0;
         end
         ERR: begin
            er = 1'b1;
            if (start) nstate = HDR0;
         end
`ifdef CHECKSUM_EN
         CSUM: begin
            rdy = 1'b1;
            bsy = 1'b1;
            if (take) nstate = (bus.in_data == csum) ? DONE : ERR;
         end
`endif
         default: nstate = IDLE;
      endcase
   end

   // Bytes land directly in the output word; wr_addr is set as the word completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n        <= '0;
         bidx     <= '0;
         wdata    <= '0;
         waddr    <= '0;
         word_cnt <= '0;
`ifdef CHECKSUM_EN
         csum     <= '0;
`endif
      end else begin
         if (can_start) begin
            word_cnt <= '0;
            bidx     <= '0;
`ifdef CHECKSUM_EN
            csum     <= '0;
`endif
         end
         if (take && state == HDR0) n[7:0] <= bus.in_data;
         if (take && state == HDR1) begin
            n[15:8] <= bus.in_data;
            bidx    <= '0;
         end
         if (take && state == DATA) begin
            wdata[{bidx, 3'b000} +: 8] <= bus.in_data;
            bidx <= bidx + 2'd1;
`ifdef CHECKSUM_EN
            csum <= csum ^ bus.in_data;
`endif
            if (bidx == 2'd3)
               waddr <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
         end
         if (state == WRITE) word_cnt <= word_cnt + 16'd1;
      end
   end

   assign bus.in_ready = rdy;
   assign bus.wr_en    = wen;
   assign bus.wr_addr  = waddr;
   assign bus.wr_data  = wdata;
   assign busy         = bsy;
   assign done         = dn;
   assign err          = er;

endmodule
